// File: rtl/ram_arbiter_ctrl_pkg.sv
// Shared encodings and helpers for the byte-wide RAM arbiter/sequencer.
// No logic of its own; imported by the top and the round-robin sub-module.
// Sizes map to a last byte index so the sequencer only counts 0..N-1.
package ram_arbiter_ctrl_pkg;

    localparam int RAM_ADDR_W = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic                  rw;
        logic [31:0]           wdata;
    } req_t;

    // Index of the final byte in a transfer (N-1).
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_legal(input logic [1:0] size, input logic [RAM_ADDR_W-1:0] addr);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !addr[0];
            SZ_WORD: return addr[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_ctrl_rr_arbiter.sv
// Two-way round-robin grant between fetch and datapath with a last-served register.
// Zero latency: grant is combinational from requests while enabled.
// No backpressure; requesters hold their request until serviced.
module ram_arbiter_ctrl_rr_arbiter (
    input  logic main_clk,
    input  logic reset,
    input  logic en,
    input  logic if_req,
    input  logic dp_req,
    output logic gnt_if,
    output logic gnt_dp
);

    // Resets to "fetch served last" so the datapath wins the first contention.
    logic last_dp;

    always_comb begin
        gnt_if = 1'b0;
        gnt_dp = 1'b0;
        if (en) begin
            if (if_req && dp_req) begin
                gnt_dp = !last_dp;
                gnt_if = last_dp;
            end else begin
                gnt_dp = dp_req;
                gnt_if = if_req;
            end
        end
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            last_dp <= 1'b0;
        end else if (gnt_dp) begin
            last_dp <= 1'b1;
        end else if (gnt_if) begin
            last_dp <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Shares a byte-wide 512-byte RAM between fetch and datapath, big-endian sequencing.
// Latency: done N+1 cycles after grant (N = 1/2/4 bytes); rejected requests finish in 1.
// Backpressure: requesters hold req until their done pulse; requests seen only in IDLE.
module ram_arbiter_ctrl
    import ram_arbiter_ctrl_pkg::*;
(
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [RAM_ADDR_W-1:0] if_addr,
    input  logic                  dp_req,
    input  logic                  dp_rw,
    input  logic [1:0]            dp_size,
    input  logic [RAM_ADDR_W-1:0] dp_addr,
    input  logic [31:0]           dp_wdata,
    output logic                  if_done,
    output logic                  dp_done,
    output logic [31:0]           rdata,
    output logic                  align_err,
    output logic                  busy,
    output logic [RAM_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    logic [1:0] state;
    logic [1:0] k;
    req_t       cur;
    logic       cur_if;
    logic       cur_err;

    logic       gnt_if;
    logic       gnt_dp;
    req_t       sel;
    logic       sel_legal;
    logic       xfer;
    logic [1:0] wr_idx;

    ram_arbiter_ctrl_rr_arbiter u_rr_arbiter (
        .main_clk (main_clk),
        .reset    (reset),
        .en       (state == ST_IDLE),
        .if_req   (if_req),
        .dp_req   (dp_req),
        .gnt_if   (gnt_if),
        .gnt_dp   (gnt_dp)
    );

    // Fetch is presented as a word read so legality and sequencing are shared.
    always_comb begin
        sel.addr  = dp_addr;
        sel.size  = dp_size;
        sel.rw    = dp_rw;
        sel.wdata = dp_wdata;
        if (gnt_if) begin
            sel.addr  = if_addr;
            sel.size  = SZ_WORD;
            sel.rw    = 1'b1;
            sel.wdata = 32'd0;
        end
        sel_legal = is_legal(sel.size, sel.addr);
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            k       <= 2'd0;
            rdata   <= 32'd0;
            cur     <= '0;
            cur_if  <= 1'b0;
            cur_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_if || gnt_dp) begin
                        cur     <= sel;
                        cur_if  <= gnt_if;
                        cur_err <= !sel_legal;
                        k       <= 2'd0;
                        state   <= sel_legal ? ST_XFER : ST_DONE;
                    end
                end
                ST_XFER: begin
                    // First byte clears the field so narrower reads zero-extend.
                    if (cur.rw) begin
                        rdata <= {(k == 2'd0) ? 24'd0 : rdata[23:0], mem_rdata};
                    end
                    if (k == last_idx(cur.size)) begin
                        state <= ST_DONE;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                ST_DONE: begin
                    k     <= 2'd0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so a reset drops them at once.
    assign xfer      = (state == ST_XFER);
    assign wr_idx    = last_idx(cur.size) - k;
    assign mem_we    = xfer && !cur.rw;
    assign mem_addr  = xfer ? cur.addr + {{(RAM_ADDR_W-2){1'b0}}, k} : '0;
    assign mem_wdata = mem_we ? cur.wdata[{wr_idx, 3'b000} +: 8] : 8'd0;

    assign if_done   = (state == ST_DONE) && cur_if;
    assign dp_done   = (state == ST_DONE) && !cur_if;
    assign align_err = (state == ST_DONE) && cur_err;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Directed bench for ram_arbiter_ctrl with a behavioural byte RAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_ram_arbiter_ctrl;

    logic        main_clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        dp_req;
    logic        dp_rw;
    logic [1:0]  dp_size;
    logic [8:0]  dp_addr;
    logic [31:0] dp_wdata;
    logic        if_done;
    logic        dp_done;
    logic [31:0] rdata;
    logic        align_err;
    logic        busy;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:511];

    int checks   = 0;
    int failures = 0;

    ram_arbiter_ctrl dut (
        .main_clk  (main_clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .dp_req    (dp_req),
        .dp_rw     (dp_rw),
        .dp_size   (dp_size),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .if_done   (if_done),
        .dp_done   (dp_done),
        .rdata     (rdata),
        .align_err (align_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 main_clk = ~main_clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge main_clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    // Issues one request and follows it to its done pulse (lat = 0 on timeout).
    task automatic run_req(input logic fetch, input logic rw, input logic [1:0] size,
                           input logic [8:0] addr, input logic [31:0] wdata,
                           output int lat, output int we_cnt, output int acc_cnt,
                           output logic [8:0] first_addr, output logic err,
                           output logic got_if, output logic got_dp);
        @(negedge main_clk);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            dp_req   = 1'b1;
            dp_rw    = rw;
            dp_size  = size;
            dp_addr  = addr;
            dp_wdata = wdata;
        end
        lat = 0; we_cnt = 0; acc_cnt = 0; first_addr = '0;
        err = 1'b0; got_if = 1'b0; got_dp = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge main_clk);
            if (if_done || dp_done) begin
                lat = c; err = align_err; got_if = if_done; got_dp = dp_done;
                break;
            end
            if (busy) begin
                if (acc_cnt == 0) first_addr = mem_addr;
                acc_cnt++;
                if (mem_we) we_cnt++;
            end
        end
        if_req = 1'b0;
        dp_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge main_clk);
        checks++;
        if ({busy, mem_we, if_done, dp_done, align_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, mem_we, if_done, dp_done, align_err});
        end
        checks++;
        if (mem_addr !== 9'd0 || mem_wdata !== 8'd0) begin
            failures++;
            $display("FAIL reset_mem: got addr %h wdata %h expected 000 00", mem_addr, mem_wdata);
        end
        checks++;
        if (rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int lat, we_cnt, acc_cnt;
        logic [8:0] fa;
        logic err, gi, gd;
        run_req(1'b1, 1'b1, 2'b10, 9'h000, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 5 || gi !== 1'b1 || gd !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done: got lat %0d if %b dp %b expected lat 5 if 1 dp 0", lat, gi, gd);
        end
        checks++;
        if (rdata !== 32'hE3A01005) begin
            failures++;
            $display("FAIL fetch_rdata: got %h expected e3a01005", rdata);
        end
        checks++;
        if (acc_cnt !== 4 || fa !== 9'h000 || we_cnt !== 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_access: got reads %0d first %h writes %0d err %b expected 4 000 0 0",
                     acc_cnt, fa, we_cnt, err);
        end
    endtask

    task automatic test_dp_write();
        int lat, we_cnt, acc_cnt;
        logic [8:0] fa;
        logic err, gi, gd;
        run_req(1'b0, 1'b0, 2'b10, 9'h040, 32'hDEADBEEF, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 5 || gd !== 1'b1 || gi !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL wword_done: got lat %0d dp %b if %b err %b expected 5 1 0 0", lat, gd, gi, err);
        end
        checks++;
        if (we_cnt !== 4 || fa !== 9'h040) begin
            failures++;
            $display("FAIL wword_we: got writes %0d first %h expected 4 040", we_cnt, fa);
        end
        checks++;
        if ({ram[9'h040], ram[9'h041], ram[9'h042], ram[9'h043]} !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wword_ram: got %h expected deadbeef",
                     {ram[9'h040], ram[9'h041], ram[9'h042], ram[9'h043]});
        end
        run_req(1'b0, 1'b0, 2'b01, 9'h046, 32'h0000A1B2, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if ({ram[9'h046], ram[9'h047]} !== 16'hA1B2 || we_cnt !== 2 || lat !== 3) begin
            failures++;
            $display("FAIL whalf: got ram %h writes %0d lat %0d expected a1b2 2 3",
                     {ram[9'h046], ram[9'h047]}, we_cnt, lat);
        end
        run_req(1'b0, 1'b0, 2'b00, 9'h044, 32'hFFFFFF55, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if ({ram[9'h044], ram[9'h045]} !== 16'h5500 || we_cnt !== 1 || lat !== 2) begin
            failures++;
            $display("FAIL wbyte: got ram %h writes %0d lat %0d expected 5500 1 2",
                     {ram[9'h044], ram[9'h045]}, we_cnt, lat);
        end
    endtask

    task automatic test_dp_read();
        int lat, we_cnt, acc_cnt;
        logic [8:0] fa;
        logic err, gi, gd;
        run_req(1'b0, 1'b1, 2'b01, 9'h042, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (rdata !== 32'h0000BEEF || lat !== 3 || we_cnt !== 0) begin
            failures++;
            $display("FAIL rhalf: got %h lat %0d writes %0d expected 0000beef 3 0", rdata, lat, we_cnt);
        end
        run_req(1'b0, 1'b1, 2'b00, 9'h041, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (rdata !== 32'h000000AD || lat !== 2 || fa !== 9'h041) begin
            failures++;
            $display("FAIL rbyte: got %h lat %0d addr %h expected 000000ad 2 041", rdata, lat, fa);
        end
    endtask

    task automatic test_illegal();
        int lat, we_cnt, acc_cnt;
        logic [8:0] fa;
        logic err, gi, gd;
        run_req(1'b0, 1'b0, 2'b10, 9'h041, 32'h12345678, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 1 || err !== 1'b1 || gd !== 1'b1) begin
            failures++;
            $display("FAIL ill_word: got lat %0d err %b dp %b expected 1 1 1", lat, err, gd);
        end
        checks++;
        if (we_cnt !== 0 || acc_cnt !== 0 || ram[9'h041] !== 8'hAD || rdata !== 32'h000000AD) begin
            failures++;
            $display("FAIL ill_side: got writes %0d acc %0d ram %h rdata %h expected 0 0 ad 000000ad",
                     we_cnt, acc_cnt, ram[9'h041], rdata);
        end
        run_req(1'b0, 1'b1, 2'b11, 9'h040, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 1 || err !== 1'b1 || acc_cnt !== 0) begin
            failures++;
            $display("FAIL ill_size: got lat %0d err %b acc %0d expected 1 1 0", lat, err, acc_cnt);
        end
        run_req(1'b0, 1'b1, 2'b01, 9'h043, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 1 || err !== 1'b1) begin
            failures++;
            $display("FAIL ill_half: got lat %0d err %b expected 1 1", lat, err);
        end
        run_req(1'b1, 1'b1, 2'b10, 9'h002, 32'd0, lat, we_cnt, acc_cnt, fa, err, gi, gd);
        checks++;
        if (lat !== 1 || err !== 1'b1 || gi !== 1'b1 || rdata !== 32'h000000AD) begin
            failures++;
            $display("FAIL ill_fetch: got lat %0d err %b if %b rdata %h expected 1 1 1 000000ad",
                     lat, err, gi, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order;
        int         done_cyc [4];
        int         n;
        int         bad_rdata;
        reset = 1'b1;
        @(negedge main_clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 9'h000;
        dp_req = 1'b1; dp_rw = 1'b1; dp_size = 2'b10; dp_addr = 9'h040;
        n = 0; order = 4'b0; bad_rdata = 0;
        for (int i = 0; i < 4; i++) done_cyc[i] = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge main_clk);
            if (if_done || dp_done) begin
                order[3-n] = dp_done;
                done_cyc[n] = c;
                if (dp_done && rdata !== 32'hDEADBEEF) bad_rdata++;
                if (if_done && rdata !== 32'hE3A01005) bad_rdata++;
                n++;
            end
        end
        if_req = 1'b0;
        dp_req = 1'b0;
        checks++;
        if (order !== 4'b1010 || n !== 4) begin
            failures++;
            $display("FAIL rr_order: got %b (%0d grants) expected 1010 (dp,if,dp,if)", order, n);
        end
        checks++;
        if (done_cyc[0] !== 5 || done_cyc[1] !== 11 || done_cyc[2] !== 17 || done_cyc[3] !== 23) begin
            failures++;
            $display("FAIL rr_timing: got %0d %0d %0d %0d expected 5 11 17 23",
                     done_cyc[0], done_cyc[1], done_cyc[2], done_cyc[3]);
        end
        checks++;
        if (bad_rdata !== 0) begin
            failures++;
            $display("FAIL rr_rdata: got %0d wrong read words expected 0", bad_rdata);
        end
        @(negedge main_clk);
    endtask

    task automatic test_reset_mid_write();
        int dones;
        @(negedge main_clk);
        dp_req = 1'b1; dp_rw = 1'b0; dp_size = 2'b10; dp_addr = 9'h080; dp_wdata = 32'h11223344;
        repeat (2) @(negedge main_clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 9'h081 || mem_wdata !== 8'h22) begin
            failures++;
            $display("FAIL abort_pre: got we %b addr %h data %h expected 1 081 22", mem_we, mem_addr, mem_wdata);
        end
        reset  = 1'b1;
        dp_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: got we %b busy %b expected 0 0", mem_we, busy);
        end
        @(negedge main_clk);
        reset = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge main_clk);
            if (if_done || dp_done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_done: got %0d active cycles expected 0", dones);
        end
        checks++;
        if ({ram[9'h080], ram[9'h081], ram[9'h082]} !== 24'h110000) begin
            failures++;
            $display("FAIL abort_ram: got %h expected 110000", {ram[9'h080], ram[9'h081], ram[9'h082]});
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        ram[0] = 8'hE3; ram[1] = 8'hA0; ram[2] = 8'h10; ram[3] = 8'h05;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dp_req = 1'b0; dp_rw = 1'b0; dp_size = 2'b00; dp_addr = '0; dp_wdata = '0;
        test_reset();
        test_fetch();
        test_dp_write();
        test_dp_read();
        test_illegal();
        test_round_robin();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_ctrl.md
RAM_ARBITER_CTRL -- requirements
Module: ram_arbiter_ctrl

Sequences and shares the byte-wide 512-byte RAM between instruction fetch and datapath load/store; big-endian (lowest address = MSB).

Interface
REQ-001 main_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 if_req  in  1  fetch request (always word read); held until if_done.
REQ-004 if_addr  in  9  fetch byte address.
REQ-005 dp_req  in  1  datapath request; held until dp_done.
REQ-006 dp_rw  in  1  1 = read, 0 = write.
REQ-007 dp_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 dp_addr  in  9  datapath byte address.
REQ-009 dp_wdata  in  32  store data, right-justified.
REQ-010 if_done / dp_done  out  1 each  one-cycle completion pulse to granted requester.
REQ-011 rdata  out  32  assembled read data, valid during done pulse, held until next grant.
REQ-012 align_err  out  1  pulses with done when the request was rejected.
REQ-013 busy  out  1  high in any non-IDLE state.
REQ-014 mem_addr  out  9; mem_we  out  1; mem_wdata  out  8; mem_rdata  in  8 (combinational RAM read of mem_addr).

Function
REQ-015 FSM states IDLE, XFER, DONE; IDLE -> XFER on grant of legal request; XFER -> DONE after last byte; DONE -> IDLE unconditionally.
REQ-016 Byte count N = 1/2/4 for byte/half/word; fetch always N = 4.
REQ-017 In XFER, 2-bit counter k runs 0..N-1; mem_addr = latched base + k; one byte per cycle.
REQ-018 Read: mem_rdata shifted into rdata LSB end each XFER cycle, so first byte ends MSB of the N-byte field; upper bits zero-extended.
REQ-019 Write: mem_we high in every XFER cycle only; mem_wdata = dp_wdata byte (N-1-k) (word: [31:24] first; half: [15:8] first; byte: [7:0]).
REQ-020 Latency: request sampled in IDLE at edge t -> done high in cycle t+N+1; no RAM access outside XFER.
REQ-021 Arbitration in IDLE: single requester wins; both -> round-robin, the requester not served last wins; after reset, dp has priority.
REQ-022 Illegal request (dp_size 11, half with addr[0]=1, word/fetch with addr[1:0]!=0): IDLE -> DONE directly, no memory access, align_err and done pulse, rdata unchanged.
REQ-023 Aligned requests never cross address 511; no wrap-around logic required.
REQ-024 Requests changing while busy are ignored; base, size, rw, wdata latched at grant.
REQ-025 A requester still high the cycle after its done pulse is treated as a new request.

Reset
REQ-026 On reset: state IDLE, k 0, rdata 0, round-robin pointer = if-served-last, all outputs 0 (mem_addr 0, mem_we 0).
REQ-027 Reset mid-transfer aborts: mem_we drops asynchronously, no done pulse, partial writes remain in RAM.

Structure
REQ-028 Shared package holds state encodings, size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and RAM_ADDR_W = 9.
REQ-029 One sub-module: rr_arbiter (2-way round-robin grant with last-served register).

Verification
REQ-030 RAM[0..3]=E3A01005, if_req addr 0 -> if_done at t+5, rdata E3A01005, 4 reads addr 0..3.
REQ-031 dp write word 0xDEADBEEF addr 0x40 -> mem_we 4 cycles, RAM[0x40..0x43]=DE,AD,BE,EF; dp_done at t+5.
REQ-032 dp read half addr 0x42 after REQ-031 -> rdata 0000BEEF; byte read 0x41 -> 000000AD.
REQ-033 if_req and dp_req together, held continuously -> grants alternate dp, if, dp, if.
REQ-034 dp word addr 0x41 -> align_err + dp_done at t+1, mem_we never high, rdata unchanged.
REQ-035 Reset asserted during 2nd byte of word write -> mem_we 0 same time, no done, state IDLE, RAM holds 1 written byte.
